i281_mc_sequencer: RTL

Multicycle control sequencer for the i281 multicycle CPU. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB phases and drives the phase strobes for the datapath. Those strobes are the instruction-register load (c16), PC write and select, flags write, register-file write and data-memory write. It sits directly downstream of the instruction-memory register: it drives that register's c16 and decodes its 16-bit output.

---
 rtl/i281_mc_pkg.sv | 68 ++++++
 rtl/i281_branch_cond.sv | 33 +++
 rtl/i281_mc_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/i281_mc_pkg.sv
// i281_mc_pkg: shared definitions for the i281 multicycle control sequencer.
//   phase_t   - sequencer phase encoding (also the value on the phase output)
//   OP_*      - 4-bit opcode constants (ir[15:12])
//   iclass_t  - instruction class, picks the phase sequence after DECODE
//   BR_*      - branch subcode constants (ir[9:8])
package i281_mc_pkg;

    typedef enum logic [2:0] {
        PH_FETCH  = 3'd0,
        PH_DECODE = 3'd1,
        PH_EXEC   = 3'd2,
        PH_MEM    = 3'd3,
        PH_WB     = 3'd4
    } phase_t;

    localparam logic [3:0] OP_NOOP   = 4'b0000;
    localparam logic [3:0] OP_INPUT  = 4'b0001;
    localparam logic [3:0] OP_MOVE   = 4'b0010;
    localparam logic [3:0] OP_LOADI  = 4'b0011;
    localparam logic [3:0] OP_ADD    = 4'b0100;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b0110;
    localparam logic [3:0] OP_SUBI   = 4'b0111;
    localparam logic [3:0] OP_LOAD   = 4'b1000;
    localparam logic [3:0] OP_LOADF  = 4'b1001;
    localparam logic [3:0] OP_STORE  = 4'b1010;
    localparam logic [3:0] OP_STOREF = 4'b1011;
    localparam logic [3:0] OP_SHIFT  = 4'b1100;
    localparam logic [3:0] OP_CMP    = 4'b1101;
    localparam logic [3:0] OP_JUMP   = 4'b1110;
    localparam logic [3:0] OP_BRX    = 4'b1111;

    typedef enum logic [2:0] {
        CL_NOOP,
        CL_ALU,
        CL_CMP,
        CL_LOAD,
        CL_STORE,
        CL_JUMP,
        CL_BRX
    } iclass_t;

    localparam logic [1:0] BR_EQ = 2'b00;   // BRE/BRZ
    localparam logic [1:0] BR_NE = 2'b01;   // BRNE/BRNZ
    localparam logic [1:0] BR_GT = 2'b10;   // BRG
    localparam logic [1:0] BR_GE = 2'b11;   // BRGE

    function automatic iclass_t op_class(input logic [3:0] op);
        iclass_t c;
        case (op)
            OP_MOVE, OP_LOADI, OP_ADD, OP_ADDI,
            OP_SUB, OP_SUBI, OP_SHIFT:            c = CL_ALU;
            OP_CMP:                               c = CL_CMP;
            OP_LOAD, OP_LOADF:                    c = CL_LOAD;
            OP_STORE, OP_STOREF, OP_INPUT:        c = CL_STORE;
            OP_JUMP:                              c = CL_JUMP;
            OP_BRX:                               c = CL_BRX;
            default:                              c = CL_NOOP;
        endcase
        return c;
    endfunction

    // MOVE and LOADI write a register but leave the flags alone.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return op inside {OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_SHIFT};
    endfunction

endpackage

// File: rtl/i281_branch_cond.sv
// i281_branch_cond: combinational branch-taken evaluation for BRx.
//   i_flags   [3:0] registered ALU flags {C,O,N,Z}
//   i_subcode [1:0] branch subcode ir[9:8]
//   o_taken         branch condition holds
module i281_branch_cond
    import i281_mc_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [1:0] i_subcode,
    output logic       o_taken
);

    logic w_o, w_n, w_z;
    logic w_unused;

    assign w_o = i_flags[2];
    assign w_n = i_flags[1];
    assign w_z = i_flags[0];
    // Carry plays no part in any branch condition.
    assign w_unused = i_flags[3];

    always_comb begin
        o_taken = 1'b0;
        case (i_subcode)
            BR_EQ:   o_taken = w_z;
            BR_NE:   o_taken = ~w_z;
            BR_GT:   o_taken = ~w_z & (w_n == w_o);
            BR_GE:   o_taken = (w_n == w_o);
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/i281_mc_sequencer.sv
// i281_mc_sequencer: multicycle control sequencer for the i281 CPU.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes combinationally from the registered phase.
//   clock, reset        rising-edge clock, async active-high reset
//   run                 global enable; low freezes phase and zeroes strobes
//   step_mode, step     single-step control (ignored when STEP_ENABLE=0)
//   ir [15:0]           latched instruction (valid from DECODE onward)
//   flags [3:0]         registered ALU flags {C,O,N,Z}
//   c16                 instruction-register load
//   pc_we, pc_sel       PC write / source (0 = PC+1, 1 = branch target)
//   flags_we, reg_we,   flag, register-file and data-memory writes
//   dmem_we
//   instr_done          last phase of the current instruction
//   phase [2:0]         current phase
module i281_mc_sequencer
    import i281_mc_pkg::*;
#(
    parameter bit STEP_ENABLE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        step_mode,
    input  logic        step,
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    output logic        c16,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        flags_we,
    output logic        reg_we,
    output logic        dmem_we,
    output logic        instr_done,
    output logic [2:0]  phase
);

    phase_t  r_phase;
    phase_t  w_next;
    iclass_t w_class;
    logic    w_taken;
    logic    w_active;
    logic    w_stall;
    logic    w_unused;

    assign w_class  = op_class(ir[15:12]);
    // Reset is folded in so strobes drop the instant reset rises, even in
    // FETCH where the phase itself would otherwise assert c16.
    assign w_active = run & ~reset;
    assign w_stall  = STEP_ENABLE & step_mode & ~step;
    assign w_unused = ^{ir[11:10], ir[7:0]};
    assign phase    = r_phase;

    i281_branch_cond u_branch_cond (
        .i_flags   (flags),
        .i_subcode (ir[9:8]),
        .o_taken   (w_taken)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_phase <= PH_FETCH;
        else       r_phase <= w_next;
    end

    always_comb begin
        w_next     = r_phase;
        c16        = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        flags_we   = 1'b0;
        reg_we     = 1'b0;
        dmem_we    = 1'b0;
        instr_done = 1'b0;
        if (w_active) begin
            case (r_phase)
                PH_FETCH: begin
                    // Step mode only gates leaving FETCH; once an instruction
                    // is released it runs to completion.
                    if (!w_stall) begin
                        c16    = 1'b1;
                        w_next = PH_DECODE;
                    end
                end
                PH_DECODE: begin
                    pc_we = 1'b1;
                    if (w_class == CL_NOOP) begin
                        instr_done = 1'b1;
                        w_next     = PH_FETCH;
                    end else begin
                        w_next = PH_EXEC;
                    end
                end
                PH_EXEC: begin
                    case (w_class)
                        CL_ALU: begin
                            flags_we = op_sets_flags(ir[15:12]);
                            w_next   = PH_WB;
                        end
                        CL_CMP: begin
                            flags_we   = 1'b1;
                            instr_done = 1'b1;
                            w_next     = PH_FETCH;
                        end
                        CL_LOAD, CL_STORE: w_next = PH_MEM;
                        CL_JUMP: begin
                            pc_we      = 1'b1;
                            pc_sel     = 1'b1;
                            instr_done = 1'b1;
                            w_next     = PH_FETCH;
                        end
                        CL_BRX: begin
                            pc_we      = w_taken;
                            pc_sel     = w_taken;
                            instr_done = 1'b1;
                            w_next     = PH_FETCH;
                        end
                        default: w_next = PH_FETCH;
                    endcase
                end
                PH_MEM: begin
                    if (w_class == CL_LOAD) begin
                        w_next = PH_WB;
                    end else begin
                        dmem_we    = (w_class == CL_STORE);
                        instr_done = 1'b1;
                        w_next     = PH_FETCH;
                    end
                end
                PH_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                    w_next     = PH_FETCH;
                end
                default: w_next = PH_FETCH;
            endcase
        end
    end

endmodule
